// File: rtl/led_cube_pkg.sv
// -----------------------------------------------------------------------------
// led_cube_pkg
// Shared types and constants for the LED cube frame path: the frame loader
// and the single-frame driver that reads the displayed frame from it.
//
// Contents:
//   FRAME_BYTES    - bytes per frame (8 row bytes x 8 layers), power of 2
//   ADDR_W         - width of a byte address within one frame
//   TIMEOUT_CYCLES - default idle allowance inside a partially loaded frame
//   loader_state_e - frame loader states
//   bank_index     - flat RAM index from a bank bit and a byte address
// -----------------------------------------------------------------------------
package led_cube_pkg;

  localparam int FRAME_BYTES    = 64;
  localparam int ADDR_W         = $clog2(FRAME_BYTES);
  localparam int TIMEOUT_CYCLES = 100000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } loader_state_e;

  // The two banks sit back to back in one array, so the bank bit is simply
  // the index MSB.
  function automatic logic [ADDR_W:0] bank_index(input logic            bank,
                                                 input logic [ADDR_W-1:0] addr);
    return {bank, addr};
  endfunction

endpackage

// File: rtl/led_frame_bank_ram.sv
// -----------------------------------------------------------------------------
// led_frame_bank_ram
// Two frame banks of FRAME_BYTES x 8 bits. One synchronous write port and one
// asynchronous (zero-latency) read port, each with its own bank select.
// Contents are never cleared.
//
// Ports:
//   clk      in   clock for the write port
//   wr_en    in   write strobe
//   wr_bank  in   bank written
//   wr_addr  in   byte address written
//   wr_data  in   byte written
//   rd_bank  in   bank read
//   rd_addr  in   byte address read
//   rd_data  out  byte at {rd_bank, rd_addr}, combinational
// -----------------------------------------------------------------------------
module led_frame_bank_ram
  import led_cube_pkg::*;
#(
  parameter int FRAME_BYTES = led_cube_pkg::FRAME_BYTES,
  parameter int ADDR_W      = led_cube_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic              wr_bank,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              rd_bank,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  logic [7:0] mem [0:2*FRAME_BYTES-1];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[{wr_bank, wr_addr}] <= wr_data;
    end
  end

  assign rd_data = mem[{rd_bank, rd_addr}];

endmodule

// File: rtl/led_frame_loader.sv
// -----------------------------------------------------------------------------
// led_frame_loader
// Assembles a host byte stream into a double-buffered frame store and serves
// the displayed bank to the single-frame driver. Banks swap only when the
// consumer signals a frame boundary and a complete frame is waiting, so a
// partially loaded frame is never shown.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for a byte flagged in_sof; other bytes are dropped
// FILL  | loading the fill bank; idle timer guards against a stalled host
// FULL  | complete frame in the fill bank, waiting for frame_boundary
//
// Ports:
//   clk             in   system clock
//   rst             in   synchronous reset, active high
//   in_valid        in   byte present on in_data
//   in_sof          in   byte is byte 0 of a frame (with in_valid)
//   in_data         in   stream byte
//   in_ready        out  byte accepted this cycle (low only in FULL)
//   frame_boundary  in   consumer pulse: bank swap permitted
//   rd_addr         in   display read address
//   rd_data         out  display-bank byte, 0 while nothing is displayed
//   frame_pending   out  complete frame waiting in the fill bank
//   disp_valid      out  display bank holds a loaded frame
//   sof_err         out  pulse: in_sof arrived mid-frame
//   timeout_err     out  pulse: partial frame abandoned on idle timeout
//   frames_shown    out  completed swap count, wrapping
// -----------------------------------------------------------------------------
module led_frame_loader
  import led_cube_pkg::*;
#(
  parameter int FRAME_BYTES    = led_cube_pkg::FRAME_BYTES,
  parameter int ADDR_W         = led_cube_pkg::ADDR_W,
  parameter int TIMEOUT_CYCLES = led_cube_pkg::TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              frame_boundary,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic              frame_pending,
  output logic              disp_valid,
  output logic              sof_err,
  output logic              timeout_err,
  output logic [15:0]       frames_shown
);

  localparam int TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_BYTES - 1);
  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);

  loader_state_e     state;
  logic              disp_bank;
  logic [ADDR_W-1:0] byte_cnt;
  logic [TMR_W-1:0]  idle_tmr;

  logic              accept;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        ram_rd_data;

  assign in_ready = (state != FULL);
  assign accept   = in_valid & in_ready;

  // In IDLE only a start-of-frame byte is stored; in FILL every accepted byte
  // is. A start-of-frame byte always lands at address 0, which also covers
  // the mid-frame resync case.
  assign wr_en   = accept & ((state == FILL) | in_sof);
  assign wr_addr = in_sof ? '0 : byte_cnt;

  led_frame_bank_ram #(
    .FRAME_BYTES (FRAME_BYTES),
    .ADDR_W      (ADDR_W)
  ) u_bank_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_bank (~disp_bank),
    .wr_addr (wr_addr),
    .wr_data (in_data),
    .rd_bank (disp_bank),
    .rd_addr (rd_addr),
    .rd_data (ram_rd_data)
  );

  // The RAM is never cleared, so a blank cube after reset comes from masking.
  assign rd_data = disp_valid ? ram_rd_data : 8'h00;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      disp_bank     <= 1'b0;
      byte_cnt      <= '0;
      idle_tmr      <= '0;
      frame_pending <= 1'b0;
      disp_valid    <= 1'b0;
      sof_err       <= 1'b0;
      timeout_err   <= 1'b0;
      frames_shown  <= 16'd0;
    end else begin
      sof_err     <= 1'b0;
      timeout_err <= 1'b0;

      unique case (state)
        IDLE: begin
          if (accept && in_sof) begin
            byte_cnt <= ADDR_W'(1);
            idle_tmr <= '0;
            state    <= FILL;
          end
        end

        FILL: begin
          if (accept) begin
            idle_tmr <= '0;
            if (in_sof) begin
              // Restart the frame in place rather than dropping to IDLE, so
              // the byte that carried in_sof is kept.
              byte_cnt <= ADDR_W'(1);
              sof_err  <= 1'b1;
            end else if (byte_cnt == LAST_ADDR) begin
              byte_cnt      <= '0;
              frame_pending <= 1'b1;
              state         <= FULL;
            end else begin
              byte_cnt <= byte_cnt + ADDR_W'(1);
            end
          end else if (idle_tmr == TMR_LAST) begin
            // Abandoned bytes stay in the fill bank; the next frame
            // overwrites every address before it can be displayed.
            byte_cnt    <= '0;
            idle_tmr    <= '0;
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            idle_tmr <= idle_tmr + TMR_W'(1);
          end
        end

        FULL: begin
          if (frame_boundary) begin
            disp_bank     <= ~disp_bank;
            disp_valid    <= 1'b1;
            frame_pending <= 1'b0;
            frames_shown  <= frames_shown + 16'd1;
            state         <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_frame_loader.sv
module tb_led_frame_loader;

  localparam int FB = 64;
  localparam int AW = 6;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_sof;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          frame_boundary;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          frame_pending;
  logic          disp_valid;
  logic          sof_err;
  logic          timeout_err;
  logic [15:0]   frames_shown;

  always #5 clk = ~clk;

  led_frame_loader #(
    .FRAME_BYTES    (FB),
    .ADDR_W         (AW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_sof         (in_sof),
    .in_data        (in_data),
    .in_ready       (in_ready),
    .frame_boundary (frame_boundary),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .frame_pending  (frame_pending),
    .disp_valid     (disp_valid),
    .sof_err        (sof_err),
    .timeout_err    (timeout_err),
    .frames_shown   (frames_shown)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a partial frame being collected, a complete frame that
  // may be waiting, and the frame currently on display.
  bit          m_live = 0;
  bit          m_loading, m_pending, m_dv;
  int          m_cnt, m_gap;
  logic [7:0]  m_fill [FB];
  logic [7:0]  m_disp [FB];
  logic [15:0] m_shown;
  bit          m_sof_p, m_to_p;
  int          sof_seen, to_seen;

  task automatic model_step();
    m_sof_p = 0;
    m_to_p  = 0;
    if (rst) begin
      m_live = 1; m_loading = 0; m_pending = 0; m_dv = 0;
      m_cnt = 0; m_gap = 0; m_shown = 16'd0;
    end else if (m_pending) begin
      if (frame_boundary) begin
        m_disp    = m_fill;
        m_dv      = 1;
        m_pending = 0;
        m_shown++;
      end
    end else if (in_valid && in_sof) begin
      if (m_loading) m_sof_p = 1;
      m_fill[0] = in_data;
      m_cnt     = 1;
      m_gap     = 0;
      m_loading = 1;
    end else if (in_valid && m_loading) begin
      m_fill[m_cnt] = in_data;
      m_cnt++;
      m_gap = 0;
      if (m_cnt == FB) begin
        m_loading = 0;
        m_pending = 1;
      end
    end else if (!in_valid && m_loading) begin
      m_gap++;
      if (m_gap == TO) begin
        m_loading = 0;
        m_to_p    = 1;
      end
    end
  endtask

  task automatic sample_and_check();
    @(negedge clk);
    if (sof_err === 1'b1) sof_seen++;
    if (timeout_err === 1'b1) to_seen++;
    if (m_live) begin
      chk("in_ready", in_ready, !m_pending);
      chk("rd_data", rd_data, m_dv ? m_disp[rd_addr] : 8'h00);
      chk("frame_pending", frame_pending, m_pending);
      chk("disp_valid", disp_valid, m_dv);
      chk("sof_err", sof_err, m_sof_p);
      chk("timeout_err", timeout_err, m_to_p);
      chk("frames_shown", frames_shown, m_shown);
    end
  endtask

  task automatic finish_cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    sample_and_check();
    finish_cycle();
  endtask

  task automatic put(input bit sof, input logic [7:0] d);
    in_valid = 1'b1;
    in_sof   = sof;
    in_data  = d;
    rd_addr  = AW'($urandom_range(0, FB - 1));
    step();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    for (int k = 0; k < n; k++) begin
      rd_addr = AW'($urandom_range(0, FB - 1));
      step();
    end
  endtask

  task automatic put_frame_random();
    put(1'b1, 8'($urandom));
    for (int k = 1; k < FB; k++) put(1'b0, 8'($urandom));
    in_valid = 1'b0;
  endtask

  task automatic pulse_boundary();
    frame_boundary = 1'b1;
    step();
    frame_boundary = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] first_after;
    int         gap_left;

    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = 8'h00;
    frame_boundary = 1'b0; rd_addr = '0;
    step();
    step();
    rst = 1'b0;

    // Blank cube after reset
    sample_and_check();
    chk("rst_dv", disp_valid, 1'b0);
    chk("rst_rdy", in_ready, 1'b1);
    finish_cycle();
    for (int a = 0; a < FB; a++) begin
      rd_addr = AW'(a);
      sample_and_check();
      chk("rst_rd", rd_data, 8'h00);
      finish_cycle();
    end

    // Frame 1: sof byte 0x81, then byte i = i
    put(1'b1, 8'h81);
    for (int i = 1; i < FB; i++) put(1'b0, 8'(i));
    in_valid = 1'b0;
    sample_and_check();
    chk("f1_pend", frame_pending, 1'b1);
    chk("f1_rdy", in_ready, 1'b0);
    finish_cycle();
    pulse_boundary();
    rd_addr = AW'(5);
    sample_and_check();
    chk("f1_a5", rd_data, 8'h05);
    chk("f1_shown", frames_shown, 16'd1);
    chk("f1_dv", disp_valid, 1'b1);
    finish_cycle();
    rd_addr = AW'(0);
    sample_and_check();
    chk("f1_a0", rd_data, 8'h81);
    finish_cycle();

    // Frame 2 (all 0xAA) held back while the source keeps presenting data
    put(1'b1, 8'hAA);
    for (int i = 1; i < FB; i++) put(1'b0, 8'hAA);
    in_valid = 1'b1; in_sof = 1'b0; in_data = 8'h55;
    for (int k = 0; k < 5; k++) begin
      rd_addr = AW'(3 + k);
      sample_and_check();
      chk("f2_rdy", in_ready, 1'b0);
      chk("f2_old", rd_data, 8'(3 + k));
      finish_cycle();
    end
    pulse_boundary();
    in_valid = 1'b0;
    for (int a = 0; a < FB; a++) begin
      rd_addr = AW'(a);
      sample_and_check();
      chk("f2_aa", rd_data, 8'hAA);
      finish_cycle();
    end
    sample_and_check();
    chk("f2_shown", frames_shown, 16'd2);
    finish_cycle();

    // Mid-frame resync
    sof_seen = 0;
    put(1'b1, 8'($urandom));
    for (int i = 1; i < 20; i++) put(1'b0, 8'($urandom));
    put(1'b1, 8'h11);
    first_after = 8'($urandom);
    put(1'b0, first_after);
    for (int i = 1; i < 63; i++) put(1'b0, 8'($urandom));
    idle(2);
    pulse_boundary();
    rd_addr = AW'(0);
    sample_and_check();
    chk("sync_a0", rd_data, 8'h11);
    finish_cycle();
    rd_addr = AW'(1);
    sample_and_check();
    chk("sync_a1", rd_data, {24'd0, first_after});
    finish_cycle();
    chk("sof_once", sof_seen, 1);

    // One idle cycle short of the timeout must not abandon the frame
    to_seen = 0;
    put(1'b1, 8'($urandom));
    put(1'b0, 8'($urandom));
    idle(TO - 1);
    for (int i = 2; i < FB; i++) put(1'b0, 8'($urandom));
    idle(1);
    chk("to_edge_none", to_seen, 0);
    pulse_boundary();

    // Timeout after 10 bytes
    to_seen = 0;
    put(1'b1, 8'($urandom));
    for (int i = 1; i < 10; i++) put(1'b0, 8'($urandom));
    idle(TO + 4);
    sample_and_check();
    chk("to_once", to_seen, 1);
    chk("to_pend", frame_pending, 1'b0);
    chk("to_rdy", in_ready, 1'b1);
    finish_cycle();
    put(1'b0, 8'h77);
    put_frame_random();
    idle(2);
    pulse_boundary();
    for (int a = 0; a < FB; a++) begin
      rd_addr = AW'(a);
      step();
    end

    // Randomized traffic
    gap_left = 0;
    for (int c = 0; c < 3000; c++) begin
      rst            = ($urandom_range(0, 499) == 0);
      frame_boundary = ($urandom_range(0, 5) == 0);
      rd_addr        = AW'($urandom_range(0, FB - 1));
      in_data        = 8'($urandom);
      if (gap_left == 0 && $urandom_range(0, 59) == 0)
        gap_left = $urandom_range(TO - 2, TO + 1);
      if (gap_left > 0) begin
        gap_left--;
        in_valid = 1'b0;
        in_sof   = 1'b0;
      end else begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_sof   = m_loading ? ($urandom_range(0, 199) == 0)
                             : ($urandom_range(0, 3) == 0);
      end
      step();
    end
    rst = 1'b0; in_valid = 1'b0; in_sof = 1'b0; frame_boundary = 1'b0;

    // Reset while a frame is pending in FULL
    rst = 1'b1;
    step();
    rst = 1'b0;
    put_frame_random();
    idle(1);
    pulse_boundary();
    put_frame_random();
    idle(1);
    sample_and_check();
    chk("rf_pend_pre", frame_pending, 1'b1);
    chk("rf_shown_pre", frames_shown, 16'd1);
    finish_cycle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    rd_addr = AW'(9);
    sample_and_check();
    chk("rf_pend", frame_pending, 1'b0);
    chk("rf_dv", disp_valid, 1'b0);
    chk("rf_rd", rd_data, 8'h00);
    chk("rf_shown", frames_shown, 16'd0);
    finish_cycle();
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
